// File: rtl/muldiv_seq_unit_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
package muldiv_seq_unit_pkg;

  // Operation select (opE)
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // HI/LO select for mfE / mtE
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_LO   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns magnitude results into signed HI/LO, including the divide-by-zero override.
module muldiv_sign_fix
  import muldiv_seq_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic             div_zero,
  input  logic             neg_res,
  input  logic             neg_rem,
  input  logic [WIDTH-1:0] mag_hi,
  input  logic [WIDTH-1:0] mag_lo,
  input  logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] cond_neg(input logic en, input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return en ? $unsigned(-s) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic en, input logic [2*WIDTH-1:0] v);
    logic signed [2*WIDTH-1:0] s;
    s = $signed(v);
    return en ? $unsigned(-s) : v;
  endfunction

  logic [2*WIDTH-1:0] prod_fix;

  assign prod_fix = cond_neg2(neg_res, {mag_hi, mag_lo});

  // Select the signed result; dividend magnitude re-signed restores the original operand
  always_comb begin
    hi = prod_fix[2*WIDTH-1:WIDTH];
    lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        lo = '1;
        hi = cond_neg(neg_rem, dividend);
      end else begin
        lo = cond_neg(neg_res, mag_lo);
        hi = cond_neg(neg_rem, mag_hi);
      end
    end
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, one result bit per cycle.
module muldiv_seq_unit
  import muldiv_seq_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [1:0]       mtE,
  input  logic [1:0]       mfE,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done,
  output logic             stallE
);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     hi, lo;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc;
  logic                 op_div, neg_res, neg_rem;
  logic                 is_signed, last_iter;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  assign is_signed = ~opE[0];
  assign a_abs     = (is_signed && SrcAE[WIDTH-1]) ? $unsigned(-$signed(SrcAE)) : SrcAE;
  assign b_abs     = (is_signed && SrcBE[WIDTH-1]) ? $unsigned(-$signed(SrcBE)) : SrcBE;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Multiply: add multiplicand into the upper half when the current multiplier bit is set
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
  // Divide: upper half is the remainder, lower half shifts dividend bits out / quotient bits in
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_mag};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (startE) state_nx = opE[1] ? DIV : MUL;
      MUL, DIV: if (last_iter) state_nx = FIX;
      FIX:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = (state != IDLE);
    done = (state == FIX);
  end

  assign stallE = busy & (startE | (mtE != SEL_NONE) | mfE[1]);

  // Iteration counter and architectural HI/LO; a start wins over a simultaneous mtE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!startE) begin
            if (mtE == SEL_HI)      hi <= SrcAE;
            else if (mtE == SEL_LO) lo <= SrcAE;
          end
        end
        MUL, DIV: cnt <= cnt + CNT_W'(1);
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  // Operand latch and shift-add / restoring-divide datapath
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (startE) begin
        a_mag   <= a_abs;
        b_mag   <= b_abs;
        op_div  <= opE[1];
        neg_res <= is_signed & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
        neg_rem <= is_signed & SrcAE[WIDTH-1];
        acc     <= opE[1] ? {WIDTH'(0), a_abs} : {WIDTH'(0), b_abs};
      end
      MUL: acc <= {mul_sum, acc[WIDTH-1:1]};
      DIV: acc <= div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
      default: ;
    endcase
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_div   (op_div),
    .div_zero (b_mag == '0),
    .neg_res  (neg_res),
    .neg_rem  (neg_rem),
    .mag_hi   (acc[2*WIDTH-1:WIDTH]),
    .mag_lo   (acc[WIDTH-1:0]),
    .dividend (a_mag),
    .hi       (fix_hi),
    .lo       (fix_lo)
  );

  // Combinational HI/LO read port
  always_comb begin
    Out = '0;
    if (mfE == SEL_HI)      Out = hi;
    else if (mfE == SEL_LO) Out = lo;
  end

endmodule
